// File: rtl/ascon_serial_host_if.sv
// Host-side bus bundle of the serial Ascon host: parallel operands and
// results on one side, 3-bit share lanes and core handshake on the other.
// Handshake: reqxSI is sampled only while busyxSO is low; one accepted
// request yields exactly one donexSO pulse, and requests seen while busy
// are dropped without being queued.
interface ascon_serial_host_if #(
    parameter int K = 128,
    parameter int L = 40,
    parameter int Y = 40
);
    logic           reqxSI;
    logic [K-1:0]   keyxDI;
    logic [127:0]   noncexDI;
    logic [L-1:0]   associated_dataxDI;
    logic [Y-1:0]   plain_textxDI;
    logic           busyxSO;
    logic           donexSO;
    logic [Y-1:0]   cipher_textxDO;
    logic [127:0]   tagxDO;
    logic [2:0]     keyxSO;
    logic [2:0]     noncexSO;
    logic [2:0]     associated_dataxSO;
    logic [2:0]     plain_textxSO;
    logic [6:0]     r_64xSO;
    logic           r_128xSO;
    logic           r_ptxSO;
    logic           encryption_startxSO;
    logic           cipher_textxSI;
    logic           tagxSI;
    logic           encryption_readyxSI;
    logic [2:0]     dbg_statexSO;

    modport slave (
        input  reqxSI, keyxDI, noncexDI, associated_dataxDI, plain_textxDI,
               cipher_textxSI, tagxSI, encryption_readyxSI,
        output busyxSO, donexSO, cipher_textxDO, tagxDO,
               keyxSO, noncexSO, associated_dataxSO, plain_textxSO,
               r_64xSO, r_128xSO, r_ptxSO, encryption_startxSO, dbg_statexSO
    );

    modport master (
        output reqxSI, keyxDI, noncexDI, associated_dataxDI, plain_textxDI,
               cipher_textxSI, tagxSI, encryption_readyxSI,
        input  busyxSO, donexSO, cipher_textxDO, tagxDO,
               keyxSO, noncexSO, associated_dataxSO, plain_textxSO,
               r_64xSO, r_128xSO, r_ptxSO, encryption_startxSO, dbg_statexSO
    );
endinterface

// File: rtl/ascon_serial_host.sv
// Serial Ascon host: latches parallel operands, streams them MSB first over
// the 3-bit share lanes with fresh LFSR randomness, starts the core, waits
// for ready and deserializes ciphertext and tag back into parallel registers.
module ascon_serial_host #(
    parameter int          K            = 128,
    parameter int          L            = 40,
    parameter int          Y            = 40,
    parameter int          MAX          = (K > L) ? ((K > Y) ? K : Y) : ((L > Y) ? L : Y),
    parameter int          START_CYCLES = 3,
    parameter int          READ_GAP     = 2,
    parameter int          MASKED       = 0,
    parameter logic [31:0] SEED         = 32'hACE1_0001
) (
    input logic               clk,
    input logic               rst,
    ascon_serial_host_if.slave bus
);
    // Galois taps for x^32+x^22+x^2+x+1 in a right-shifting register
    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam int          CW     = $clog2(MAX + START_CYCLES + READ_GAP + 1);
    localparam logic        MASK_EN = (MASKED != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_GAP   = 3'd4,
        S_READ  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [L-1:0]   ad_q, ad_d;
    logic [Y-1:0]   pt_q, pt_d;
    logic [Y-1:0]   ct_q, ct_d;
    logic [127:0]   tag_q, tag_d;
    logic [16:0]    rnd;
    logic [31:0]    lfsr_adv;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: each phase is timed by the shared counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.reqxSI) state_d = S_LOAD;
            S_LOAD:  if (cnt_q == CW'(MAX - 1)) state_d = S_START;
            S_START: if (cnt_q == CW'(START_CYCLES - 1)) state_d = S_WAIT;
            S_WAIT:  if (bus.encryption_readyxSI) state_d = (READ_GAP == 0) ? S_READ : S_GAP;
            S_GAP:   if (cnt_q == CW'(READ_GAP - 1)) state_d = S_READ;
            S_READ:  if (cnt_q == CW'(MAX - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // 17 LFSR steps per cycle; each step's shifted-out bit is one random bit,
    // first step lands in rnd[16] so the vector reads MSB first
    always_comb begin
        lfsr_adv = lfsr_q;
        rnd      = '0;
        for (int k = 0; k < 17; k++) begin
            rnd[16-k] = lfsr_adv[0];
            lfsr_adv  = {1'b0, lfsr_adv[31:1]} ^ (lfsr_adv[0] ? TAPS : 32'h0);
        end
    end

    // Datapath: counter restarts on every phase change, operands shift out
    // MSB first (zero fill covers operands shorter than MAX), readback fills LSB first
    always_comb begin
        cnt_d   = (state_q == S_IDLE || state_d != state_q) ? '0 : cnt_q + CW'(1);
        lfsr_d  = (state_q == S_LOAD) ? lfsr_adv : lfsr_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ad_d    = ad_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        tag_d   = tag_q;
        case (state_q)
            S_IDLE: begin
                if (bus.reqxSI) begin
                    key_d   = bus.keyxDI;
                    nonce_d = bus.noncexDI;
                    ad_d    = bus.associated_dataxDI;
                    pt_d    = bus.plain_textxDI;
                end
            end
            S_LOAD: begin
                key_d   = key_q << 1;
                nonce_d = nonce_q << 1;
                ad_d    = ad_q << 1;
                pt_d    = pt_q << 1;
            end
            S_READ: begin
                for (int b = 0; b < Y; b++)
                    if (cnt_q == CW'(b)) ct_d[b] = bus.cipher_textxSI;
                for (int b = 0; b < 128; b++)
                    if (cnt_q == CW'(b)) tag_d[b] = bus.tagxSI;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            lfsr_q  <= SEED;
            key_q   <= '0;
            nonce_q <= '0;
            ad_q    <= '0;
            pt_q    <= '0;
            ct_q    <= '0;
            tag_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ad_q    <= ad_d;
            pt_q    <= pt_d;
            ct_q    <= ct_d;
            tag_q   <= tag_d;
        end
    end

    // Outputs decoded from state; lanes and randomness are live only in LOAD
    always_comb begin
        bus.busyxSO             = (state_q != S_IDLE);
        bus.donexSO             = (state_q == S_DONE);
        bus.encryption_startxSO = (state_q == S_START);
        bus.r_128xSO            = 1'b0;
        bus.r_ptxSO             = 1'b0;
        bus.r_64xSO             = '0;
        bus.keyxSO              = '0;
        bus.associated_dataxSO  = '0;
        bus.plain_textxSO       = '0;
        bus.noncexSO            = '0;
        if (state_q == S_LOAD) begin
            bus.r_128xSO           = rnd[16];
            bus.r_ptxSO            = rnd[15];
            bus.r_64xSO            = rnd[14:8];
            bus.keyxSO             = {rnd[7:6], key_q[K-1]   ^ (MASK_EN & (rnd[7] ^ rnd[6]))};
            bus.associated_dataxSO = {rnd[5:4], ad_q[L-1]    ^ (MASK_EN & (rnd[5] ^ rnd[4]))};
            bus.plain_textxSO      = {rnd[3:2], pt_q[Y-1]    ^ (MASK_EN & (rnd[3] ^ rnd[2]))};
            bus.noncexSO           = {rnd[1:0], nonce_q[127] ^ (MASK_EN & (rnd[1] ^ rnd[0]))};
        end
    end

    assign bus.cipher_textxDO = ct_q;
    assign bus.tagxDO         = tag_q;
    assign bus.dbg_statexSO   = state_q;
endmodule

// File: tb/tb_ascon_serial_host.sv
// Bench for ascon_serial_host: an unmasked and a masked instance run in
// lockstep; a cycle-level reference model pushes expected outputs, a monitor
// pops and compares them, and observers check timing properties.
module tb_ascon_serial_host;
    localparam int          K = 128, L = 40, Y = 40, MAX = 128;
    localparam int          START_CYCLES = 3, READ_GAP = 2;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    localparam logic [127:0] KEY   = 128'h2db083053e848cefa30007336c47a5a1;
    localparam logic [127:0] NONCE = 128'h3f3607dbce3503ba84f5843d623de056;
    localparam logic [39:0]  AD    = 40'h4153434f4e;
    localparam logic [39:0]  PT    = 40'h6173636f6e;

    typedef struct packed {
        logic         busy, done, start;
        logic [2:0]   kl, nl, al, pl;
        logic [6:0]   r64;
        logic         r128, rpt;
        logic [39:0]  ct;
        logic [127:0] tag;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic clk = 1'b0;
    logic rst = 1'b0;

    ascon_serial_host_if #(.K(K), .L(L), .Y(Y)) if_p ();
    ascon_serial_host_if #(.K(K), .L(L), .Y(Y)) if_m ();

    ascon_serial_host #(.K(K), .L(L), .Y(Y), .MAX(MAX), .START_CYCLES(START_CYCLES),
        .READ_GAP(READ_GAP), .MASKED(0), .SEED(SEED)) dut_p (.clk(clk), .rst(rst), .bus(if_p));
    ascon_serial_host #(.K(K), .L(L), .Y(Y), .MAX(MAX), .START_CYCLES(START_CYCLES),
        .READ_GAP(READ_GAP), .MASKED(1), .SEED(SEED)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

    assign if_m.reqxSI              = if_p.reqxSI;
    assign if_m.keyxDI              = if_p.keyxDI;
    assign if_m.noncexDI            = if_p.noncexDI;
    assign if_m.associated_dataxDI  = if_p.associated_dataxDI;
    assign if_m.plain_textxDI       = if_p.plain_textxDI;
    assign if_m.cipher_textxSI      = if_p.cipher_textxSI;
    assign if_m.tagxSI              = if_p.tagxSI;
    assign if_m.encryption_readyxSI = if_p.encryption_readyxSI;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] expm_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_done_exp = 0;
    int txn_no = 0;
    logic [31:0]  m_lfsr;
    logic [39:0]  m_ct;
    logic [127:0] m_tag;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e, em;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            em = expm_q.pop_front();
            chk("ctrl_p", {if_p.busyxSO, if_p.donexSO, if_p.encryption_startxSO}, {e.busy, e.done, e.start});
            chk("lanes_p", {if_p.keyxSO, if_p.noncexSO, if_p.associated_dataxSO, if_p.plain_textxSO,
                            if_p.r_64xSO, if_p.r_128xSO, if_p.r_ptxSO},
                           {e.kl, e.nl, e.al, e.pl, e.r64, e.r128, e.rpt});
            chk("ct_p", if_p.cipher_textxDO, e.ct);
            chk("tag_p", if_p.tagxDO, e.tag);
            chk("ctrl_m", {if_m.busyxSO, if_m.donexSO, if_m.encryption_startxSO}, {em.busy, em.done, em.start});
            chk("lanes_m", {if_m.keyxSO, if_m.noncexSO, if_m.associated_dataxSO, if_m.plain_textxSO,
                            if_m.r_64xSO, if_m.r_128xSO, if_m.r_ptxSO},
                           {em.kl, em.nl, em.al, em.pl, em.r64, em.r128, em.rpt});
            chk("ct_m", if_m.cipher_textxDO, em.ct);
            chk("tag_m", if_m.tagxDO, em.tag);
        end
    end

    // ---------------- timing observers ----------------
    int done_cnt = 0, start_run = 0, start_runs_n = 0, start_bad = 0;
    int busy_cyc = 0, load_len = -1;
    logic start_seen = 1'b0;
    logic [2:0] key_first = '0;
    logic mchg = 1'b0;
    logic [1:0] mprev = '0;
    logic [20:0] lane_a [MAX];
    logic [20:0] lane_b [MAX];

    always @(negedge clk) begin
        logic [20:0] vec;
        vec = {if_p.keyxSO, if_p.noncexSO, if_p.associated_dataxSO, if_p.plain_textxSO,
               if_p.r_64xSO, if_p.r_128xSO, if_p.r_ptxSO};
        if (if_p.donexSO) done_cnt++;
        if (if_p.encryption_startxSO) start_run++;
        else if (start_run != 0) begin
            start_runs_n++;
            if (start_run != START_CYCLES) start_bad++;
            start_run = 0;
        end
        if (if_p.busyxSO) begin
            if (if_p.encryption_startxSO && !start_seen) begin
                start_seen = 1'b1;
                if (txn_no == 1) load_len = busy_cyc;
            end
            if (busy_cyc < MAX) begin
                if (txn_no == 1) begin
                    lane_a[busy_cyc] = vec;
                    if (busy_cyc < 3) key_first[busy_cyc] = if_p.keyxSO[0];
                    if (busy_cyc > 0 && if_m.keyxSO[2:1] != mprev) mchg = 1'b1;
                    mprev = if_m.keyxSO[2:1];
                end
                if (txn_no == 4) lane_b[busy_cyc] = vec;
            end
            busy_cyc++;
        end else begin
            busy_cyc   = 0;
            start_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t idle_rec();
        exp_t e;
        e     = '0;
        e.ct  = m_ct;
        e.tag = m_tag;
        return e;
    endfunction

    task automatic push2(input exp_t e, input exp_t em);
        exp_q.push_back(e);
        expm_q.push_back(em);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            if_p.reqxSI              = 1'b0;
            if_p.encryption_readyxSI = 1'b0;
            if_p.cipher_textxSI      = 1'($urandom_range(0, 1));
            if_p.tagxSI              = 1'($urandom_range(0, 1));
            push2(idle_rec(), idle_rec());
            step();
        end
    endtask

    // One transaction, cycle 0 being the accept cycle. Ready is high during
    // cycles rdy_at .. rdy_at+rdy_len-1; rej_a/rej_b pulse req while busy;
    // rst_at (if >0) asserts reset in that cycle and abandons the transaction.
    task automatic run_txn(input logic [127:0] key, input logic [127:0] nonce,
                           input logic [39:0] ad, input logic [39:0] pt,
                           input int rdy_at, input int rdy_len, input int rej_a, input int rej_b,
                           input int rst_at, input logic [39:0] ct_bits, input logic [127:0] tag_bits);
        exp_t e, em;
        int rs, i, j;
        logic rdy, si_c, si_t, rd;
        logic [16:0] rb;
        logic dk, dn, da, dp;
        if_p.keyxDI = key; if_p.noncexDI = nonce;
        if_p.associated_dataxDI = ad; if_p.plain_textxDI = pt;
        if_p.reqxSI = 1'b1; if_p.encryption_readyxSI = 1'b0;
        push2(idle_rec(), idle_rec());
        step();
        // operands are captured; scramble the host inputs to prove it
        if_p.keyxDI = {$urandom, $urandom, $urandom, $urandom};
        if_p.noncexDI = {$urandom, $urandom, $urandom, $urandom};
        if_p.associated_dataxDI = {8'($urandom), $urandom};
        if_p.plain_textxDI = {8'($urandom), $urandom};
        rs = -1;
        for (int c = 1; c < 4000; c++) begin
            rdy = (c >= rdy_at) && (c < rdy_at + rdy_len);
            if_p.encryption_readyxSI = rdy;
            if_p.reqxSI = (c == rej_a) || (c == rej_b);
            si_c = 1'($urandom_range(0, 1));
            si_t = 1'($urandom_range(0, 1));
            rd = 1'b0; j = 0;
            if (c == rst_at) begin
                rst = 1'b0;
                m_ct = '0; m_tag = '0; m_lfsr = SEED;
                push2(idle_rec(), idle_rec());
                step();
                push2(idle_rec(), idle_rec());
                step();
                rst = 1'b1;
                if_p.reqxSI = 1'b0; if_p.encryption_readyxSI = 1'b0;
                return;
            end
            e = idle_rec();
            e.busy = 1'b1;
            if (c <= MAX) begin
                i = c - 1;
                for (int k = 0; k < 17; k++) begin
                    rb[k]  = m_lfsr[0];
                    m_lfsr = (m_lfsr >> 1) ^ (rb[k] ? POLY : 32'h0);
                end
                dk = (i < K) ? key[K-1-i] : 1'b0;
                dn = (i < 128) ? nonce[127-i] : 1'b0;
                da = (i < L) ? ad[L-1-i] : 1'b0;
                dp = (i < Y) ? pt[Y-1-i] : 1'b0;
                e.r128 = rb[0];
                e.rpt  = rb[1];
                for (int b = 0; b < 7; b++) e.r64[6-b] = rb[2+b];
                e.kl = {rb[9],  rb[10], dk};
                e.al = {rb[11], rb[12], da};
                e.pl = {rb[13], rb[14], dp};
                e.nl = {rb[15], rb[16], dn};
                em = e;
                em.kl[0] = dk ^ rb[9]  ^ rb[10];
                em.al[0] = da ^ rb[11] ^ rb[12];
                em.pl[0] = dp ^ rb[13] ^ rb[14];
                em.nl[0] = dn ^ rb[15] ^ rb[16];
            end else begin
                if (c <= MAX + START_CYCLES) e.start = 1'b1;
                else if (rs < 0 || c <= rs + READ_GAP) begin
                    if (rs < 0 && rdy) rs = c;
                end else if (c <= rs + READ_GAP + MAX) begin
                    rd = 1'b1;
                    j  = c - rs - READ_GAP - 1;
                    if (j < Y) si_c = ct_bits[j];
                    if (j < 128) si_t = tag_bits[j];
                end else e.done = 1'b1;
                em = e;
            end
            if_p.cipher_textxSI = si_c;
            if_p.tagxSI = si_t;
            push2(e, em);
            step();
            if (rd) begin
                if (j < Y) m_ct[j] = si_c;
                if (j < 128) m_tag[j] = si_t;
            end
            if (e.done) begin
                if_p.reqxSI = 1'b0; if_p.encryption_readyxSI = 1'b0;
                n_done_exp++;
                return;
            end
        end
        chk("txn_bound", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int mism;
        if_p.reqxSI = 1'b0; if_p.encryption_readyxSI = 1'b0;
        if_p.keyxDI = '0; if_p.noncexDI = '0;
        if_p.associated_dataxDI = '0; if_p.plain_textxDI = '0;
        if_p.cipher_textxSI = 1'b0; if_p.tagxSI = 1'b0;
        m_lfsr = SEED; m_ct = '0; m_tag = '0;
        rst = 1'b0;
        step();
        idle(3);
        rst = 1'b1;
        idle(2);

        // directed vectors, ready 50 cycles after start falls
        txn_no = 1;
        run_txn(KEY, NONCE, AD, PT, MAX + START_CYCLES + 50, 1, -1, -1, -1,
                40'haaaaaaaaaa, {128{1'b1}});
        chk("ct_directed", if_p.cipher_textxDO, 40'haaaaaaaaaa);
        chk("tag_directed", if_p.tagxDO, {128{1'b1}});
        idle(3);

        // requests while busy (LOAD and WAIT) must be ignored
        txn_no = 2;
        run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                {8'($urandom), $urandom}, {8'($urandom), $urandom},
                MAX + START_CYCLES + 20, 2, 30, MAX + 10, -1,
                {8'($urandom), $urandom}, {$urandom, $urandom, $urandom, $urandom});
        idle(2);

        // reset at LOAD index 60, then replay the directed vectors
        txn_no = 3;
        run_txn(KEY, NONCE, AD, PT, MAX + START_CYCLES + 5, 1, -1, -1, 61, '0, '0);
        idle(2);
        txn_no = 4;
        run_txn(KEY, NONCE, AD, PT, MAX + START_CYCLES + 5, 1, -1, -1, -1,
                {8'($urandom), $urandom}, {$urandom, $urandom, $urandom, $urandom});
        idle(2);

        // ready already high when WAIT is entered
        txn_no = 5;
        run_txn(KEY, {$urandom, $urandom, $urandom, $urandom}, {8'($urandom), $urandom}, PT,
                MAX + 2, 10, -1, -1, -1,
                {8'($urandom), $urandom}, {$urandom, $urandom, $urandom, $urandom});
        idle(1);

        // random transactions
        for (int t = 0; t < 4; t++) begin
            txn_no = 6 + t;
            run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    {8'($urandom), $urandom}, {8'($urandom), $urandom},
                    MAX + START_CYCLES + $urandom_range(1, 30), $urandom_range(1, 5), -1, -1, -1,
                    {8'($urandom), $urandom}, {$urandom, $urandom, $urandom, $urandom});
            idle($urandom_range(1, 4));
        end
        idle(2);

        // final report
        mism = 0;
        for (int c = 0; c < MAX; c++) if (lane_a[c] !== lane_b[c]) mism++;
        chk("replay_lanes_mismatches", mism, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses", done_cnt, n_done_exp);
        chk("start_pulses", start_runs_n, n_done_exp);
        chk("start_width_bad", start_bad, 0);
        chk("load_cycles", load_len, MAX);
        chk("key_bits_0_2", key_first, 3'b100);
        chk("masked_rand_changes", mchg, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ascon_serial_host.md
Name: ascon_serial_host

Overview:
- Host-side counterpart of the serial Ascon encryption core.
- Takes parallel key/nonce/AD/PT, adds fresh random share bits and shifts the operands into the core over the 3-bit share lanes, MSB first.
- Pulses the core's start, waits for its ready, then deserializes ciphertext and tag into parallel registers.
- Sits between the system bus/register file and the Ascon core.

Parameters:
- K, 128, key width (bits).
- L, 40, associated-data width.
- Y, 40, plaintext/ciphertext width.
- MAX, max(K,L,Y), serial load/read length in cycles. MAX >= 128 is required so the full tag is read.
- START_CYCLES, 3, cycles encryption_startxSO is held high.
- READ_GAP, 2, cycles between ready seen and first output bit sampled.
- MASKED, 0:
  - 0: lane[0] = data bit, lane[2:1] random.
  - 1: lane[0] = data ^ lane[1] ^ lane[2].
- SEED, 32'hACE1_0001, LFSR reset value. Must be nonzero.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- reqxSI  in  1  start a transaction (accepted only in IDLE)
- keyxDI  in  K  key
- noncexDI  in  128  nonce
- associated_dataxDI  in  L  associated data
- plain_textxDI  in  Y  plaintext
- busyxSO  out  1  high in every state except IDLE
- donexSO  out  1  one-cycle pulse when ct/tag are valid
- cipher_textxDO  out  Y  captured ciphertext
- tagxDO  out  128  captured tag
- keyxSO, noncexSO, associated_dataxSO, plain_textxSO  out  3 each  serial share lanes to core
- r_64xSO  out  7  fresh randomness to core
- r_128xSO, r_ptxSO  out  1 each  fresh randomness to core
- encryption_startxSO  out  1  core start
- cipher_textxSI, tagxSI  in  1 each  serial outputs from core
- encryption_readyxSI  in  1  core done, level-sensitive, same clock domain

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0, including cipher_textxDO and tagxDO.
  - Counter 0; LFSR = SEED.
- FSM: IDLE -> LOAD -> START -> WAIT -> GAP -> READ -> DONE -> IDLE.
- IDLE:
  - reqxSI=1 latches all four parallel operands into shadow registers, clears the counter, goes to LOAD.
  - Host inputs may change after the accept cycle.
- LOAD, MAX cycles, counter i = 0..MAX-1. Lane bit0 carries:
  - key[K-1-i], nonce[127-i], ad[L-1-i], pt[Y-1-i].
  - An index beyond an operand's width drives data bit 0.
- LOAD randomness:
  - 17 random bits per cycle fill r_128, r_pt, r_64[6:0] and lanes[2:1] of key, ad, pt, nonce, in that bit order, MSB first.
  - Source: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced 17 steps per LOAD cycle (combinational unroll).
  - LFSR frozen outside LOAD.
- Outside LOAD, all lane/r outputs = 0.
- START: encryption_startxSO=1 for exactly START_CYCLES cycles, then WAIT.
- WAIT: stay until encryption_readyxSI=1. No timeout. Ready already high on WAIT entry is accepted in that first WAIT cycle.
- GAP: READ_GAP idle cycles. A ready deassert during GAP is ignored.
- READ, MAX cycles, j = 0..MAX-1, sampled at the rising edge:
  - cipher_textxDO[j] <= cipher_textxSI for j<Y.
  - tagxDO[j] <= tagxSI for j<128.
  - Bits beyond those widths are discarded.
- DONE: donexSO=1 for one cycle, then IDLE. cipher_textxDO/tagxDO hold until overwritten by the next READ.
- reqxSI while busy: ignored, no queuing.
- Latency with accept at cycle t:
  - first LOAD cycle t+1;
  - start high t+MAX+1 .. t+MAX+START_CYCLES;
  - done = ready-seen cycle + READ_GAP + MAX + 1.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. Partial ct/tag are cleared.

Test Plan:
- Lane values: defaults, MASKED=0, key=2db083053e848cefa30007336c47a5a1, nonce=3f3607dbce3503ba84f5843d623de056, AD=4153434f4e, PT=6173636f6e.
  - Reconstructed lane[0] streams equal the operands MSB first: key bits at i=0,1,2 = 0,0,1.
  - ad/pt lanes are 0 for i>=40.
  - Exactly 128 LOAD cycles.
- Masked mode: MASKED=1, same vectors -> every LOAD cycle lane[0]^lane[1]^lane[2] equals the data bit; lane[2:1] not constant over 128 cycles.
- Start/ready/readback:
  - Core stub raises ready 50 cycles after start falls, drives cipher_textxSI = j[0] and tagxSI = 1.
  - Required: start high exactly 3 cycles; cipher_textxDO = aaaaaaaaaa; tagxDO = all ones; donexSO pulses once at ready+2+128+1.
- Busy rejection: reqxSI pulsed during LOAD and WAIT -> no restart; counter continues; single donexSO.
- Reset mid-LOAD: rst low at i=60 -> outputs 0 asynchronously, LFSR=SEED. A new req then replays identical lane streams to the first run.
- Ready already high on WAIT entry -> READ begins exactly READ_GAP cycles after entry.
